// File: rtl/systolic_mm_engine_if.sv
`default_nettype none
// =============================================================================
// systolic_mm_engine_if : tile handshake and result bus of the systolic engine
// Rev 1.0
// =============================================================================
interface systolic_mm_engine_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 5,
  parameter int DW    = 8,
  parameter int ACCW  = 16,
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX + 1)
);
  logic                       start;
  logic [KW-1:0]              k_len;
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*DW-1:0]         a_vec;
  logic [COLS*DW-1:0]         b_vec;
  logic                       busy;
  logic                       done;
  logic                       c_valid;
  logic [ROWS*COLS*ACCW-1:0]  c_bus;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  in_ready, busy, done, c_valid, c_bus
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output in_ready, busy, done, c_valid, c_bus
  );
endinterface
`default_nettype wire

// File: rtl/systolic_mm_engine.sv
`default_nettype none
// =============================================================================
// systolic_mm_engine : output-stationary C = A x B with internal diagonal skew.
// Optional macro SAT_ACC_EN: saturating accumulators.          Rev 1.0
// =============================================================================
module systolic_mm_engine #(
  parameter int ROWS  = 4,
  parameter int COLS  = 5,
  parameter int DW    = 8,
  parameter int ACCW  = 16,
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input wire                 clk,
  input wire                 rst_n,
  systolic_mm_engine_if.slave bus
);

  localparam int c_chain_len = ROWS + COLS - 1;
  localparam int c_dcw       = $clog2(ROWS + COLS);
  localparam logic [c_dcw-1:0] c_drain_last = c_dcw'(ROWS + COLS - 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_load  = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [KW-1:0]     r_klen;
  logic [KW-1:0]     r_xfer;
  logic [KW-1:0]     w_klen_cl;
  logic [c_dcw-1:0]  r_drain;
  logic              r_done;
  logic              w_start_acc;
  logic              w_xfer;
  logic              w_in_ready;
  logic              w_busy;

  // One shift register per A row / B column; PE(i,j) taps stage i+j of both,
  // which realises the skew and the right/down propagation in one structure.
  logic signed [DW-1:0]   r_a_sr [ROWS][c_chain_len];
  logic signed [DW-1:0]   r_b_sr [COLS][c_chain_len];
  logic signed [ACCW-1:0] r_acc      [ROWS][COLS];
  logic signed [ACCW-1:0] w_acc_next [ROWS][COLS];
  logic [ROWS*COLS*ACCW-1:0] w_c_flat;

  assign w_klen_cl   = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign w_start_acc = bus.start && ((r_state == c_idle) || (r_state == c_done));
  assign w_xfer      = bus.in_valid && w_in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle, c_done: begin
        if (bus.start) w_next = (w_klen_cl == '0) ? c_drain : c_load;
      end
      c_load: begin
        if (w_xfer && ((r_xfer + KW'(1)) == r_klen)) w_next = c_drain;
      end
      c_drain: begin
        if (r_drain == c_drain_last) w_next = c_done;
      end
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      c_load: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      c_drain: w_busy = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_klen  <= '0;
      r_xfer  <= '0;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (w_next == c_done) && (r_state != c_done);
      if (w_start_acc) begin
        r_klen <= w_klen_cl;
        r_xfer <= '0;
      end else if (w_xfer) begin
        r_xfer <= r_xfer + KW'(1);
      end
      if (r_state == c_drain) r_drain <= r_drain + c_dcw'(1);
      else                    r_drain <= '0;
    end
  end

  // --------------------------------------------------------- skew chains
  // Anything other than an accepted transfer enters as zero, so bubbles and
  // the drain phase add nothing to the accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int d = 0; d < c_chain_len; d++) r_a_sr[i][d] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int d = 0; d < c_chain_len; d++) r_b_sr[j][d] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        r_a_sr[i][0] <= w_xfer ? $signed(bus.a_vec[(i+1)*DW-1 -: DW]) : '0;
        for (int d = 1; d < c_chain_len; d++) r_a_sr[i][d] <= r_a_sr[i][d-1];
      end
      for (int j = 0; j < COLS; j++) begin
        r_b_sr[j][0] <= w_xfer ? $signed(bus.b_vec[(j+1)*DW-1 -: DW]) : '0;
        for (int d = 1; d < c_chain_len; d++) r_b_sr[j][d] <= r_b_sr[j][d-1];
      end
    end
  end

  // ---------------------------------------------------------- PE array
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [2*DW-1:0] w_prod;
      logic signed [ACCW-1:0] w_ext;

      assign w_prod = (2*DW)'(r_a_sr[i][i+j]) * (2*DW)'(r_b_sr[j][i+j]);
      assign w_ext  = ACCW'(w_prod);

`ifdef SAT_ACC_EN
      logic signed [ACCW:0]   w_sum;
      logic signed [ACCW-1:0] w_sat;

      assign w_sum = (ACCW+1)'(r_acc[i][j]) + (ACCW+1)'(w_ext);

      // Top two sum bits disagree only when the ACCW-bit range was left.
      always_comb begin
        w_sat = w_sum[ACCW-1:0];
        if (w_sum[ACCW] != w_sum[ACCW-1])
          w_sat = w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end

      assign w_acc_next[i][j] = w_sat;
`else
      assign w_acc_next[i][j] = r_acc[i][j] + w_ext;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) r_acc[i][j] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          r_acc[i][j] <= w_start_acc ? '0 : w_acc_next[i][j];
    end
  end

  always_comb begin
    w_c_flat = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        w_c_flat[(i*COLS+j)*ACCW +: ACCW] = r_acc[i][j];
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.c_valid  = (r_state == c_done);
  assign bus.c_bus    = w_c_flat;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mm_engine.sv
`default_nettype none
// =============================================================================
// tb_systolic_mm_engine : directed table plus random tiles against a matrix model
// Rev 1.0
// =============================================================================
module tb_systolic_mm_engine;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int DW    = 8;
  localparam int ACCW  = 16;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int LAT   = ROWS + COLS;

`ifdef SAT_ACC_EN
  localparam longint E_OVF = 32767;
  localparam longint E_NEG = -32768;
`else
  localparam longint E_OVF = -1020;
  localparam longint E_NEG = 512;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_mm_engine_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW),
                          .K_MAX(K_MAX), .KW(KW)) bus ();

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW),
                       .K_MAX(K_MAX), .KW(KW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  int     ga    [ROWS][K_MAX];
  int     gb    [K_MAX][COLS];
  longint exp_c [ROWS][COLS];

  typedef struct {
    int     k;
    int     amode;
    int     aval;
    int     bval;
    int     gap;
    bit     b2b;
    longint e00;
    longint e04;
    longint e34;
    string  name;
  } vec_t;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic longint c_elem(input int i, input int j);
    logic signed [ACCW-1:0] v;
    v = bus.c_bus[(i*COLS+j)*ACCW +: ACCW];
    return longint'(v);
  endfunction

  // Reduce an exact integer to what an ACCW-bit accumulator can hold.
  function automatic longint fit(input longint v);
`ifdef SAT_ACC_EN
    longint hi, lo;
    hi = (longint'(1) <<< (ACCW-1)) - 1;
    lo = -(longint'(1) <<< (ACCW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    longint m, r;
    m = longint'(1) <<< ACCW;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
`endif
  endfunction

  task automatic build_model(input int keff);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        longint acc;
        acc = 0;
        for (int kk = 0; kk < keff; kk++)
          acc = fit(acc + longint'(ga[i][kk]) * longint'(gb[kk][j]));
        exp_c[i][j] = acc;
      end
  endtask

  // amode 0: sequential A/B, 1: identity A with sequential B, 2: constants, 3: random
  task automatic fill(input int amode, input int aval, input int bval);
    for (int i = 0; i < ROWS; i++)
      for (int kk = 0; kk < K_MAX; kk++)
        case (amode)
          0:       ga[i][kk] = 4 * i + kk + 1;
          1:       ga[i][kk] = (i == kk) ? 1 : 0;
          2:       ga[i][kk] = aval;
          default: ga[i][kk] = int'($urandom_range(0, 255)) - 128;
        endcase
    for (int kk = 0; kk < K_MAX; kk++)
      for (int j = 0; j < COLS; j++)
        case (amode)
          0, 1:    gb[kk][j] = 5 * kk + j + 1;
          2:       gb[kk][j] = bval;
          default: gb[kk][j] = int'($urandom_range(0, 255)) - 128;
        endcase
  endtask

  task automatic compare_tile(input string tag);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        check($sformatf("%s C(%0d,%0d)", tag, i, j), c_elem(i, j), exp_c[i][j]);
  endtask

  // Entered #1 after an edge in IDLE/DONE; returns #1 after the edge raising done.
  task automatic run_tile(input string tag, input int k, input int gap,
                          input bit mid_start, input bit drain_junk);
    int keff;
    int n;
    bit hs_bad;
    keff = (k > K_MAX) ? K_MAX : k;
    build_model(keff);
    hs_bad = 1'b0;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int kk = 0; kk < keff; kk++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      bus.in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) bus.a_vec[(i+1)*DW-1 -: DW] = DW'(ga[i][kk]);
      for (int j = 0; j < COLS; j++) bus.b_vec[(j+1)*DW-1 -: DW] = DW'(gb[kk][j]);
      if (bus.in_ready !== 1'b1) hs_bad = 1'b1;
      if (mid_start && kk == 1) begin
        bus.start = 1'b1;
        bus.k_len = '0;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = drain_junk;
    bus.a_vec    = (ROWS*DW)'($urandom);
    bus.b_vec    = (COLS*DW)'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 4 * LAT) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hs_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check({tag, " handshake"}, longint'(hs_bad), 0);
    check({tag, " latency"}, n, LAT);
    check({tag, " c_valid"}, longint'(bus.c_valid), 1);
    check({tag, " busy"}, longint'(bus.busy), 0);
    compare_tile(tag);
  endtask

  task automatic hold_step(input string tag);
    @(posedge clk); #1;
    check({tag, " done width"}, longint'(bus.done), 0);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, " c_valid held"}, longint'(bus.c_valid), 1);
    check({tag, " C held"}, c_elem(ROWS-1, COLS-1), exp_c[ROWS-1][COLS-1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [6];
    string prev;

    tbl[0] = '{4, 0, 0,    0,   0, 1'b0, 110,   150,   750,   "functional"};
    tbl[1] = '{4, 0, 0,    0,   2, 1'b0, 110,   150,   750,   "bubbles"};
    tbl[2] = '{4, 1, 0,    0,   0, 1'b1, 1,     5,     20,    "identity_b2b"};
    tbl[3] = '{0, 0, 0,    0,   0, 1'b0, 0,     0,     0,     "zero_depth"};
    tbl[4] = '{4, 2, 127,  127, 0, 1'b0, E_OVF, E_OVF, E_OVF, "overflow_pos"};
    tbl[5] = '{4, 2, -128, 127, 0, 1'b0, E_NEG, E_NEG, E_NEG, "overflow_neg"};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.a_vec    = '0;
    bus.b_vec    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", longint'(bus.in_ready), 0);
    check("reset busy",     longint'(bus.busy), 0);
    check("reset done",     longint'(bus.done), 0);
    check("reset c_valid",  longint'(bus.c_valid), 0);
    check("reset c_bus zero", longint'(bus.c_bus == '0), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle busy", longint'(bus.busy), 0);

    prev = "";
    for (int r = 0; r < 6; r++) begin
      if (r > 0 && !tbl[r].b2b) hold_step(prev);
      fill(tbl[r].amode, tbl[r].aval, tbl[r].bval);
      run_tile(tbl[r].name, tbl[r].k, tbl[r].gap, 1'b0, 1'b0);
      check({tbl[r].name, " C(0,0) const"}, c_elem(0, 0), tbl[r].e00);
      check({tbl[r].name, " C(0,4) const"}, c_elem(0, 4), tbl[r].e04);
      check({tbl[r].name, " C(3,4) const"}, c_elem(3, 4), tbl[r].e34);
      prev = tbl[r].name;
    end
    hold_step(prev);

    // Reset pulse while the pipeline is draining.
    fill(3, 0, 0);
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int kk = 0; kk < 3; kk++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) bus.a_vec[(i+1)*DW-1 -: DW] = DW'(ga[i][kk]);
      for (int j = 0; j < COLS; j++) bus.b_vec[(j+1)*DW-1 -: DW] = DW'(gb[kk][j]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre-reset busy", longint'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid-reset busy",     longint'(bus.busy), 0);
    check("mid-reset in_ready", longint'(bus.in_ready), 0);
    check("mid-reset done",     longint'(bus.done), 0);
    check("mid-reset c_valid",  longint'(bus.c_valid), 0);
    check("mid-reset c_bus zero", longint'(bus.c_bus == '0), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset idle c_valid", longint'(bus.c_valid), 0);
    fill(3, 0, 0);
    run_tile("post_reset", 5, 0, 1'b0, 1'b0);

    // Random tiles: random depth and bubbles, one clamped depth, one ignored
    // mid-LOAD start, junk in_valid during drain, some back-to-back starts.
    for (int t = 0; t < 10; t++) begin
      int k;
      k = int'($urandom_range(0, K_MAX));
      if (t == 2 && k < 2) k = 2;
      if (t == 3) k = K_MAX + 4;
      if (t % 3 != 0) hold_step($sformatf("rand%0d_pre", t));
      fill(3, 0, 0);
      run_tile($sformatf("rand%0d_k%0d", t, k), k, -1, (t == 2), t[0]);
    end
    hold_step("rand_last");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
